// File: rtl/led_fade_pkg.sv
// Shared defaults, channel state enum and saturating step helper for the LED fade PWM block.
package led_fade_pkg;

  localparam int CHANNELS_DEF = 8;
  localparam int PWM_BITS_DEF = 8;
  localparam int RAMP_DIV_DEF = 4096;
  localparam int STEP_DEF     = 1;

  // Wide enough for any practical PWM_BITS plus the saturation guard bit.
  localparam int SAT_W = 17;

  typedef enum logic [1:0] {OFF, RISING, ON, FALLING} chan_state_e;

  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] val,
                                                input logic [SAT_W-1:0] delta,
                                                input logic [SAT_W-1:0] max,
                                                input logic             up);
    logic [SAT_W:0] sum;
    sum = {1'b0, val} + {1'b0, delta};
    if (up) return (sum > {1'b0, max}) ? max : sum[SAT_W-1:0];
    return (val > delta) ? (val - delta) : '0;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One fading channel: target bit, brightness level, shadow duty and PWM comparator.
// Define LED_FADE_GAMMA_EN for a square-law duty curve (one extra pipeline stage).
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tick,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                pattern_bit,
  input  logic                pattern_vld,
  output logic                pwm_out,
  output logic                busy_nxt
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  chan_state_e         state;
  logic                target_q, target_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, duty_src;
  logic                pwm_q, pwm_d;
  logic [SAT_W-1:0]    ramp_val;

  always_comb begin
    if (target_q) state = (level_q == MAX) ? ON  : RISING;
    else          state = (level_q == '0)  ? OFF : FALLING;
  end

`ifdef LED_FADE_GAMMA_EN
  localparam int PW = 2 * PWM_BITS;
  logic [PWM_BITS-1:0] gamma_q, gamma_d;
  logic [PW-1:0]       prod;

  // (level+1)*level / 2^PWM_BITS keeps both endpoints exact.
  always_comb begin
    prod    = (PW'(level_q) + PW'(1)) * PW'(level_q);
    gamma_d = PWM_BITS'(prod >> PWM_BITS);
  end

  always_ff @(posedge CLK) begin
    if (RST) gamma_q <= '0;
    else     gamma_q <= gamma_d;
  end

  assign duty_src = gamma_q;
`else
  assign duty_src = level_q;
`endif

  always_comb begin
    ramp_val = sat_step(SAT_W'(level_q), SAT_W'(STEP), SAT_W'(MAX), target_q);
    target_d = pattern_vld ? pattern_bit : target_q;
    level_d  = level_q;
    // A tick uses the target held before any same-cycle strobe.
    if (tick && (state == RISING || state == FALLING)) level_d = PWM_BITS'(ramp_val);
    duty_d   = wrap ? duty_src : duty_q;
    pwm_d    = (pwm_cnt < duty_q);
    busy_nxt = (level_d != (target_d ? MAX : '0));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      target_q <= 1'b0;
      level_q  <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      level_q  <= level_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

  a_on_holds:  assert property (@(posedge CLK) disable iff (RST)
                                (tick && state == ON)  |=> (level_q == MAX));
  a_off_holds: assert property (@(posedge CLK) disable iff (RST)
                                (tick && state == OFF) |=> (level_q == '0));

endmodule

// File: rtl/led_fade_pwm.sv
// Soft-fading PWM driver for an 8-bit blink pattern; owns the shared counters and busy flag.
// LED_FADE_GAMMA_EN selects the gamma duty curve inside each channel.
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int RAMP_DIV = RAMP_DIV_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] pattern_in,
  input  logic                pattern_vld,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic                busy
);

  localparam int                  PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                period_start_q, period_start_d;
  logic                busy_q, busy_d;
  logic                wrap, tick;
  logic [CHANNELS-1:0] busy_nxt;

  // Period is MAX cycles: the counter never reaches MAX, so duty MAX is always on.
  always_comb begin
    wrap           = (pwm_cnt_q == CNT_LAST);
    pwm_cnt_d      = wrap ? '0 : pwm_cnt_q + PWM_BITS'(1);
    tick           = (pre_q == PRE_LAST);
    pre_d          = tick ? '0 : pre_q + PRE_W'(1);
    period_start_d = (pwm_cnt_q == '0);
    busy_d         = |busy_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt_q      <= '0;
      pre_q          <= '0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      pre_q          <= pre_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .tick        (tick),
      .wrap        (wrap),
      .pwm_cnt     (pwm_cnt_q),
      .pattern_bit (pattern_in[i]),
      .pattern_vld (pattern_vld),
      .pwm_out     (pwm_out[i]),
      .busy_nxt    (busy_nxt[i])
    );
  end

  assign period_start = period_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: cycle-indexed reference model feeds a queue, monitor compares.
module tb_led_fade_pwm;

  localparam int CH  = 8;
  localparam int PB  = 4;
  localparam int RD  = 4;
  localparam int ST  = 1;
  localparam int MAX = 15;
`ifdef LED_FADE_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic [CH-1:0] pat;
  logic [CH-1:0] pwm;
  logic          ps;
  logic          busy;

  always #5 clk = ~clk;

  led_fade_pwm #(
    .CHANNELS (CH),
    .PWM_BITS (PB),
    .RAMP_DIV (RD),
    .STEP     (ST)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .pattern_in   (pat),
    .pattern_vld  (vld),
    .pwm_out      (pwm),
    .period_start (ps),
    .busy         (busy)
  );

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          ps;
    logic          busy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: k counts clock edges since reset release; the spec's counters are k mod N.
  int m_level[CH];
  int m_target[CH];
  int m_duty[CH];
  int m_gam[CH];
  int k;

  function automatic int gam(input int l);
    return ((l + 1) * l) >> PB;
  endfunction

  task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [CH-1:0] p);
    exp_t e;
    int   phase;
    bit   tk;
    e = '0;
    if (r) begin
      for (int i = 0; i < CH; i++) begin
        m_level[i] = 0; m_target[i] = 0; m_duty[i] = 0; m_gam[i] = 0;
      end
      k = 0;
    end else begin
      phase = k % MAX;
      tk    = ((k % RD) == RD - 1);
      e.ps  = (phase == 0);
      for (int i = 0; i < CH; i++) begin
        e.pwm[i] = (phase < m_duty[i]);
        if (phase == MAX - 1) m_duty[i] = GAMMA ? m_gam[i] : m_level[i];
        m_gam[i] = gam(m_level[i]);
        if (tk) begin
          if (m_target[i] != 0) m_level[i] = (m_level[i] + ST > MAX) ? MAX : m_level[i] + ST;
          else                  m_level[i] = (m_level[i] - ST < 0)   ? 0   : m_level[i] - ST;
        end
        if (v) m_target[i] = int'(p[i]);
        if (m_level[i] != ((m_target[i] != 0) ? MAX : 0)) e.busy = 1'b1;
      end
      k++;
    end
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic v, input logic [CH-1:0] p);
    rst = r; vld = v; pat = p;
    @(posedge clk);
    model_edge(r, v, p);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, CH'($urandom));
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pwm_out",      pwm,        e.pwm);
      chk("period_start", CH'(ps),    CH'(e.ps));
      chk("busy",         CH'(busy),  CH'(e.busy));
    end
  end

  initial begin
    rst = 1'b1; vld = 1'b0; pat = 8'hFF;
    k   = 0;
    // Reset with a pending pattern but no strobe.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hFF);
    idle(20);
    // Single channel full ramp up, then steady on.
    step(1'b0, 1'b1, 8'h01);
    idle(90);
    // Ramp down to mid level, reverse, then reverse again mid-ramp.
    step(1'b0, 1'b1, 8'h00);
    idle(32);
    step(1'b0, 1'b1, 8'h01);
    idle(21);
    step(1'b0, 1'b1, 8'h00);
    idle(40);
    // Strobe landing exactly on a tick cycle.
    while ((k % RD) != RD - 1) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hAA);
    idle(9);
    while ((k % RD) != RD - 1) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55);
    idle(70);
    // Reset mid-ramp and mid-period; nothing should ramp afterwards.
    step(1'b0, 1'b1, 8'h0F);
    idle(37);
    step(1'b1, 1'b0, 8'hFF);
    idle(40);
    // Randomized traffic including occasional resets.
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 29) == 0), CH'($urandom));
    step(1'b0, 1'b1, 8'hFF);
    idle(80);
    #2;
    chk("queue_drained", CH'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
